// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART user-port arbitration logic.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_WIDTH_DEFAULT = 8;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Ceiling log2; clog2(1) == 0, so callers clamp to a minimum width of 1.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Rotating-priority pick: first set request strictly after last_grant, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   i_req         request vector, one bit per requester
//   i_last_grant  index of the most recently served requester (lowest priority)
//   o_grant       one-hot pick, zero when no request
//   o_grant_idx   binary index of the pick
//   o_any_req     at least one request is set
module rr_arbiter_core
    import uart_pkg::*;
#(
    parameter int  P_REQ_NUM = 4,
    localparam int IDX_W     = (clog2(P_REQ_NUM) < 1) ? 1 : clog2(P_REQ_NUM)
) (
    input  logic [P_REQ_NUM-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last_grant,
    output logic [P_REQ_NUM-1:0] o_grant,
    output logic [IDX_W-1:0]     o_grant_idx,
    output logic                 o_any_req
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk the ring starting one past the last winner; the last winner itself
    // is visited last, which gives it the lowest priority.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_req   = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 1; i <= P_REQ_NUM; i++) begin
            cand = int'(i_last_grant) + i;
            if (cand >= P_REQ_NUM) begin
                cand = cand - P_REQ_NUM;
            end
            cand_idx = IDX_W'(cand);
            if (!o_any_req && i_req[cand_idx]) begin
                o_any_req         = 1'b1;
                o_grant[cand_idx] = 1'b1;
                o_grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART tx user port among P_REQ_NUM requesters, round-robin with frame lock.
// Latency: 1 cycle request-to-grant; data path combinational while locked.
// Backpressure: i_tx_ready passes straight to the granted requester's ready; others see 0.
//
// Ports:
//   i_clk, i_rst_n    user clock, async active-low reset
//   i_req_data/valid/last, o_req_ready   per-requester beat interface (data at [k*W +: W])
//   o_tx_data/o_tx_valid, i_tx_ready     toward the UART driver user port
//   o_grant           registered one-hot grant, 0 when none
//   o_busy            high while a requester holds the port
//   o_timeout_pulse   one-cycle pulse on the cycle an idle-timeout release happens
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int P_REQ_NUM         = 4,
    parameter int P_UART_DATA_WIDTH = UART_DATA_WIDTH_DEFAULT,
    parameter int P_MAX_BURST       = 16,
    parameter int P_IDLE_TIMEOUT    = 64
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_REQ_NUM-1:0]                   i_req_valid,
    input  logic [P_REQ_NUM-1:0]                   i_req_last,
    output logic [P_REQ_NUM-1:0]                   o_req_ready,
    output logic [P_UART_DATA_WIDTH-1:0]           o_tx_data,
    output logic                                   o_tx_valid,
    input  logic                                   i_tx_ready,
    output logic [P_REQ_NUM-1:0]                   o_grant,
    output logic                                   o_busy,
    output logic                                   o_timeout_pulse
);

    localparam int IDX_W  = (clog2(P_REQ_NUM) < 1) ? 1 : clog2(P_REQ_NUM);
    localparam int IDLE_W = (clog2(P_IDLE_TIMEOUT + 1) < 1) ? 1 : clog2(P_IDLE_TIMEOUT + 1);

    localparam logic [7:0]        BURST_LAST     = 8'(P_MAX_BURST - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST      = IDLE_W'((P_IDLE_TIMEOUT == 0) ? 0 : P_IDLE_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  LAST_GRANT_RST = IDX_W'(P_REQ_NUM - 1);
    localparam logic              TIMEOUT_EN     = (P_IDLE_TIMEOUT != 0);

    state_t                 state_q;
    state_t                 state_d;
    logic [IDX_W-1:0]       last_grant_q;
    logic [IDX_W-1:0]       gnt_idx_q;
    logic [P_REQ_NUM-1:0]   grant_q;
    logic [7:0]             beat_cnt_q;
    logic [IDLE_W-1:0]      idle_cnt_q;

    logic [P_REQ_NUM-1:0]   arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;

    logic [P_UART_DATA_WIDTH-1:0] g_data;
    logic                   g_valid;
    logic                   g_last;
    logic                   xfer;
    logic                   frame_release;
    logic                   idle_expire;

    rr_arbiter_core #(
        .P_REQ_NUM    (P_REQ_NUM)
    ) u_rr_core (
        .i_req        (i_req_valid),
        .i_last_grant (last_grant_q),
        .o_grant      (arb_grant),
        .o_grant_idx  (arb_idx),
        .o_any_req    (arb_any)
    );

    // Select the granted requester's lane with constant slices only.
    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int k = 0; k < P_REQ_NUM; k++) begin
            if (gnt_idx_q == IDX_W'(k)) begin
                g_data  = i_req_data[k*P_UART_DATA_WIDTH +: P_UART_DATA_WIDTH];
                g_valid = i_req_valid[k];
                g_last  = i_req_last[k];
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d         = state_q;
        o_tx_data       = '0;
        o_tx_valid      = 1'b0;
        o_req_ready     = '0;
        o_timeout_pulse = 1'b0;
        xfer            = 1'b0;
        frame_release   = 1'b0;
        idle_expire     = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (arb_any) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                o_tx_data     = g_data;
                o_tx_valid    = g_valid;
                o_req_ready   = grant_q & {P_REQ_NUM{i_tx_ready}};
                xfer          = g_valid && i_tx_ready;
                frame_release = xfer && (g_last || (beat_cnt_q == BURST_LAST));
                // The counter holds the number of idle cycles already seen, so the
                // cycle where it equals timeout-1 is the timeout-th idle cycle.
                idle_expire     = TIMEOUT_EN && !g_valid && (idle_cnt_q == IDLE_LAST);
                o_timeout_pulse = idle_expire;
                if (frame_release || idle_expire) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant_q <= LAST_GRANT_RST;
            gnt_idx_q    <= '0;
            grant_q      <= '0;
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
        end else if (state_q == ST_ARB) begin
            if (arb_any) begin
                grant_q   <= arb_grant;
                gnt_idx_q <= arb_idx;
            end
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            if (frame_release || idle_expire) begin
                // The released requester becomes lowest priority for the next pick.
                last_grant_q <= gnt_idx_q;
                grant_q      <= '0;
                beat_cnt_q   <= '0;
                idle_cnt_q   <= '0;
            end else begin
                if (xfer) begin
                    beat_cnt_q <= beat_cnt_q + 8'd1;
                end
                if (g_valid) begin
                    idle_cnt_q <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                end
            end
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q == ST_LOCK);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit user port (data/valid/ready) between P_REQ_NUM requesters.
- Uses round-robin arbitration with frame locking.
- Sits between user logic and the UART driver's i_user_tx_data / i_user_tx_valid / o_user_tx_ready, in the driver's user clock domain (o_user_clk).
- A granted requester keeps the port until its frame ends, a burst limit is hit, or it stalls past an idle timeout.

Parameters:
- P_REQ_NUM, 4, number of requesters (2..8)
- P_UART_DATA_WIDTH, 8, data width per beat
- P_MAX_BURST, 16, maximum beats per grant before forced release (1..255)
- P_IDLE_TIMEOUT, 64, cycles of valid low while locked before forced release; 0 = disabled

Ports:
- i_clk  in  1  user clock (UART driver user clock)
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_req_data  in  P_REQ_NUM*P_UART_DATA_WIDTH  requester k data at [k*W +: W]
- i_req_valid  in  P_REQ_NUM  per-requester beat valid
- i_req_last  in  P_REQ_NUM  per-requester last beat of frame
- o_req_ready  out  P_REQ_NUM  per-requester ready
- o_tx_data  out  P_UART_DATA_WIDTH  to UART driver tx data
- o_tx_valid  out  1  to UART driver tx valid
- i_tx_ready  in  1  from UART driver tx ready
- o_grant  out  P_REQ_NUM  one-hot current grant, 0 when none
- o_busy  out  1  high while in LOCK
- o_timeout_pulse  out  1  one-cycle pulse on idle-timeout release

Behaviour:
- Handshake: a beat transfers when valid and ready are both high on the same i_clk rising edge. Data is held by the source until accepted.
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low (i_rst_n); internal logic is synchronous to i_clk.
- Reset values: state=ARB, last_grant=P_REQ_NUM-1 (requester 0 wins first), beat_cnt=0, idle_cnt=0. o_grant=0, o_busy=0, o_tx_valid=0, o_tx_data=0, o_req_ready=0, o_timeout_pulse=0.
- State ARB:
  - o_tx_valid=0, all o_req_ready=0.
  - If any i_req_valid is set, pick the first set bit searching from last_grant+1 upward with wrap-around.
  - Register the grant, go to LOCK next cycle.
  - Arbitration latency: 1 cycle from valid to grant; the first beat can transfer in the cycle after grant.
  - No request: stay in ARB.
- State LOCK (granted index g):
  - Output path is combinational: o_tx_data=data[g], o_tx_valid=i_req_valid[g], o_req_ready[g]=i_tx_ready; other readys are 0.
  - Each transfer increments beat_cnt.
  - Release to ARB on the transferring edge when i_req_last[g]=1 or beat_cnt+1==P_MAX_BURST.
  - On release, last_grant<=g and beat_cnt<=0.
  - idle_cnt increments each cycle i_req_valid[g]=0 and clears on valid high.
  - If P_IDLE_TIMEOUT!=0 and idle_cnt reaches P_IDLE_TIMEOUT-1 with valid still low: release, last_grant<=g, o_timeout_pulse=1 for one cycle.
- ARB always spends at least one cycle between grants. Back-to-back frames from different requesters therefore have a 1-cycle bubble.
- Simultaneous requests: resolved purely by rotating priority; no requester waits more than P_REQ_NUM-1 grants.
- Release and a new request on the same edge: the new request is evaluated in ARB on the next cycle. The just-released requester has lowest priority.
- Changes to non-granted requester inputs during LOCK are ignored.
- Reset mid-frame: immediate return to reset values. A partially sent frame is abandoned; recovery is the requester's responsibility.
- Counter widths: beat_cnt is 8 bits; idle_cnt is clog2(P_IDLE_TIMEOUT+1) bits, minimum 1.
- o_grant is registered and one-hot; o_busy equals (state==LOCK).

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (ST_ARB=0, ST_LOCK=1)
  - function clog2
  - default data width constant
- One sub-module, rr_arbiter_core: combinational rotating-priority pick.
  - Inputs: request vector, last_grant.
  - Outputs: one-hot grant, grant index, any_req.
  - Reusable for a future RX demux.

Test Plan (N=4, W=8, P_MAX_BURST=4, P_IDLE_TIMEOUT=8):
1. Reset release, req0 sends 0x55,0xAA with last on 0xAA, i_tx_ready=1. Expected: o_grant=0001 one cycle after valid; o_tx_data 0x55 then 0xAA; return to ARB; o_grant=0.
2. All four valid continuously with single-beat frames (last=1). Expected: grant order 0,1,2,3,0; exactly one ARB bubble between grants.
3. Req2 sends 6 beats, last on the 6th. Expected: forced release after beat 4. If req3 is waiting it is granted next; req2 is re-granted after it for beats 5–6.
4. Req1 granted, sends 1 beat, then drops valid for 10 cycles. Expected: o_timeout_pulse high exactly at the 8th idle cycle, return to ARB; req1 retains no priority.
5. i_tx_ready held low 20 cycles while req0 is valid with 0x3C. Expected: o_tx_data stable at 0x3C, o_req_ready[0]=0, no timeout (valid high); transfer occurs on the first ready cycle.
6. Assert i_rst_n low mid-frame during LOCK of req3. Expected: all outputs go to reset values asynchronously; after release, req0 wins if both req0 and req3 request.
